wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RETIRE_W, default 32: width of the retire counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_to_wb_reg_valid  input  1  MEM stage presents a valid instruction on mem_data.
REQ-005 mem_data  input  74  MEM->WB bundle: [31:0] result, [36:32] rd, [37] rf_we, [69:38] pc, [70] halt, [73:71] reserved (ignored).
REQ-006 mem_wb_reg_allow_in  output  1  WB can accept a new bundle this cycle.
REQ-007 wb_stall  input  1  external hold of the WB slot (debug/test backpressure).
REQ-008 wb_rd  output  5  register-file write address.
REQ-009 wb_wdata  output  32  register-file write data.
REQ-010 wb_we  output  1  register-file write enable.
REQ-011 wb_valid  output  1  WB slot holds a valid instruction (hazard/forwarding use).
REQ-012 wb_pc  output  32  pc of the instruction in the WB slot.
REQ-013 retire_cnt  output  RETIRE_W  count of retired instructions.
REQ-014 halted  output  1  core has retired a halt instruction.

Function
REQ-015 WB slot SHALL be a single pipeline register plus valid bit; a transfer occurs when mem_to_wb_reg_valid && mem_wb_reg_allow_in at a rising edge.
REQ-016 ready_go SHALL equal !wb_stall; mem_wb_reg_allow_in SHALL equal !halted && (!wb_valid || ready_go).
REQ-017 On a transfer, the slot SHALL capture mem_data and set wb_valid=1 the next cycle (latency 1 cycle, MEM->WB).
REQ-018 If the slot retires (wb_valid && ready_go) with no incoming transfer, wb_valid SHALL clear next cycle.
REQ-019 Simultaneous retire and transfer SHALL replace the slot contents with no bubble (full throughput, 1 instr/cycle).
REQ-020 While wb_valid && !ready_go the slot contents SHALL hold unchanged and allow_in SHALL be 0.
REQ-021 wb_we SHALL equal wb_valid && ready_go && rf_we && (rd != 0); writes to x0 suppressed.
REQ-022 wb_rd, wb_wdata, wb_pc SHALL reflect the slot fields combinationally; values undefined-but-stable when wb_valid=0 (drive 0).
REQ-023 retire_cnt SHALL increment by 1 on each cycle where wb_valid && ready_go, wrapping modulo 2^RETIRE_W.
REQ-024 FSM states RUN, HALTED: RUN->HALTED when a slot with halt=1 retires; HALTED exits only via reset.
REQ-025 The halt instruction itself SHALL still perform its register write (if any) and count as retired.
REQ-026 In HALTED: allow_in=0, no further transfers, wb_valid=0 from the cycle after the halt retires, retire_cnt frozen.
REQ-027 Reserved bits [73:71] SHALL have no effect on any output.

Reset
REQ-028 On reset: wb_valid=0, slot fields=0, retire_cnt=0, FSM=RUN, halted=0; hence wb_we=0 and allow_in=1 in the first cycle after reset.
REQ-029 reset asserted mid-stall or mid-halt SHALL discard the slot without a register write and take priority over any transfer that cycle.

Structure
REQ-030 Shared package SHALL hold mem_data field offsets/widths (RESULT, RD, RF_WE, PC, HALT), the 74-bit bundle width, and the FSM state encoding.
REQ-031 One sub-module, pipe_slot (generic valid/allow_in pipeline register, width parameter), is natural; FSM, write gating and counter stay in wb_stage.

Verification
REQ-032 Reset 2 cycles, then rd=1, wdata=32'd1, rf_we=1 valid one cycle -> next cycle wb_we=1, wb_rd=1, wb_wdata=1, retire_cnt=1.
REQ-033 Back-to-back 4 valid bundles (rd=1..4) with wb_stall=0 -> allow_in stays 1, four consecutive wb_we pulses, retire_cnt=4.
REQ-034 Bundle rd=2 captured, wb_stall=1 for 3 cycles -> wb_we=0, allow_in=0, slot held; stall drop -> single write rd=2, cnt+1.
REQ-035 Bundle rd=0, rf_we=1, wdata=32'hdead_beef -> wb_we stays 0, retire_cnt still increments.
REQ-036 Bundle halt=1, rd=5, wdata=7 followed by valid bundle rd=6 -> rd=5 written, halted=1, allow_in=0, rd=6 never written, cnt frozen; reset -> RUN, cnt=0.
REQ-037 Preload retire_cnt path with RETIRE_W=4, retire 17 instructions -> retire_cnt=1 (wrap).

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: MEM->WB bundle layout and FSM encoding.
package wb_stage_pkg;

   localparam int BUNDLE_W   = 74;
   localparam int PAYLOAD_W  = 71;  // bits [70:0]; [73:71] are reserved and never stored
   localparam int RESULT_LSB = 0;
   localparam int RESULT_W   = 32;
   localparam int RD_LSB     = 32;
   localparam int RD_W       = 5;
   localparam int RF_WE_BIT  = 37;
   localparam int PC_LSB     = 38;
   localparam int PC_W       = 32;
   localparam int HALT_BIT   = 70;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   typedef struct packed {
      logic              halt;
      logic [PC_W-1:0]   pc;
      logic              rf_we;
      logic [RD_W-1:0]   rd;
      logic [RESULT_W-1:0] result;
   } wb_payload_t;

   function automatic wb_payload_t unpack_payload(input logic [PAYLOAD_W-1:0] b);
      wb_payload_t p;
      p.result = b[RESULT_LSB +: RESULT_W];
      p.rd     = b[RD_LSB +: RD_W];
      p.rf_we  = b[RF_WE_BIT];
      p.pc     = b[PC_LSB +: PC_W];
      p.halt   = b[HALT_BIT];
      return p;
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake: MEM side is master (drives valid/data), WB side is slave (drives allow_in).
interface wb_stage_if;
   import wb_stage_pkg::*;

   logic                mem_to_wb_reg_valid;
   logic [BUNDLE_W-1:0] mem_data;
   logic                mem_wb_reg_allow_in;

   modport master (output mem_to_wb_reg_valid, output mem_data, input mem_wb_reg_allow_in);
   modport slave  (input mem_to_wb_reg_valid, input mem_data, output mem_wb_reg_allow_in);

endinterface

// File: rtl/wb_stage_pipe_slot.sv
// Generic single-entry pipeline register with valid bit and allow_in handshake.
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         ready_go,
   input  logic         block,
   input  logic         drop,
   output logic         allow_in,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic load;

   assign allow_in = !block && (!out_valid || ready_go);
   // drop discards an accepted bundle instead of latching it
   assign load     = in_valid && allow_in && !drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (ready_go) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one slot register, register-file write gating, retire counter, halt FSM.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   wb_stage_if.slave           mem,
   input  logic                wb_stall,
   output logic [RD_W-1:0]     wb_rd,
   output logic [RESULT_W-1:0] wb_wdata,
   output logic                wb_we,
   output logic                wb_valid,
   output logic [PC_W-1:0]     wb_pc,
   output logic [RETIRE_W-1:0] retire_cnt,
   output logic                halted
);

   logic [0:0]           state;
   logic                 ready_go;
   logic                 retire;
   logic                 halt_retire;
   logic [PAYLOAD_W-1:0] slot_q;
   wb_payload_t          slot;
   logic                 unused_rsvd;

   assign unused_rsvd = &{1'b0, mem.mem_data[BUNDLE_W-1:PAYLOAD_W]};

   assign ready_go    = !wb_stall;
   assign halted      = (state == ST_HALTED);
   assign slot        = unpack_payload(slot_q);
   assign retire      = wb_valid && ready_go;
   assign halt_retire = retire && slot.halt;

   // A bundle arriving as the halt retires is swallowed so the slot empties
   pipe_slot #(.W(PAYLOAD_W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mem.mem_to_wb_reg_valid),
      .in_data   (mem.mem_data[PAYLOAD_W-1:0]),
      .ready_go  (ready_go),
      .block     (halted),
      .drop      (halt_retire),
      .allow_in  (mem.mem_wb_reg_allow_in),
      .out_valid (wb_valid),
      .out_data  (slot_q)
   );

   assign wb_we    = retire && slot.rf_we && (slot.rd != '0);
   assign wb_rd    = wb_valid ? slot.rd     : '0;
   assign wb_wdata = wb_valid ? slot.result : '0;
   assign wb_pc    = wb_valid ? slot.pc     : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:    if (halt_retire) state <= ST_HALTED;
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       retire_cnt <= '0;
      else if (retire) retire_cnt <= retire_cnt + 1'b1;
   end

endmodule
